pulse_edge_generation: RTL

Programmable single-pulse generator: the transmit side of the team's pulse edge detectors. It accepts a one-cycle start strobe and drives a clean, glitch-free pulse on o_pulse after a programmed delay and for a programmed width. It enforces a minimum low (holdoff) time between pulses, so that the pos/neg/both-edge detectors downstream see every edge. It sits in front of the detection blocks in stimulus and loopback paths.

---
 rtl/pulse_gen_pkg.sv | 25 ++
 rtl/pulse_edge_generation_sat_counter.sv | 34 +++
 rtl/pulse_edge_generation.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the programmable single-pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int CNT_W_DEF   = 16;
    localparam int HOLDOFF_DEF = 2;
    localparam int DROP_W_DEF  = 8;

    localparam int HOLDOFF_MIN = 1;
    localparam int HOLDOFF_MAX = 255;

    // Out-of-range holdoff values are pinned to the nearest legal bound.
    function automatic int holdoff_clamp(input int h);
        if (h < HOLDOFF_MIN) return HOLDOFF_MIN;
        if (h > HOLDOFF_MAX) return HOLDOFF_MAX;
        return h;
    endfunction

endpackage

// File: rtl/pulse_edge_generation_sat_counter.sv
// Saturating up-counter with synchronous clear; one cycle from inc_i to cnt_o.
// No backpressure: increments beyond all-ones are discarded.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_edge_generation.sv
// Single-pulse generator: start -> DELAY cycles -> WIDTH-cycle pulse -> HOLDOFF low cycles.
// Pulse rises D+1 cycles after the start cycle; starts while busy are dropped and counted.
module pulse_edge_generation
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF,
    parameter int DROP_W  = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_delay,
    input  logic [CNT_W-1:0]  i_width,
    output logic              o_pulse,
    output logic              o_ready,
    output logic              o_done,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam int               HOLD_EFF = holdoff_clamp(HOLDOFF);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   width_clamp;
    logic               pulse_q, done_q, done_d;
    logic               accept;

    assign width_clamp = (i_width == '0) ? ONE : i_width;
    assign accept      = (state_q == ST_IDLE) && i_start && !i_abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    width_d = width_clamp;
                    if (i_delay != '0) begin
                        state_d = ST_DELAY;
                        cnt_d   = i_delay;
                    end else begin
                        state_d = ST_ACTIVE;
                        cnt_d   = width_clamp;
                    end
                end
            end
            ST_DELAY: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == ONE) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_ACTIVE: begin
                // Abort still passes through HOLDOFF so the low time is guaranteed.
                if (i_abort || (cnt_q == ONE)) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLD_LD;
                    done_d  = !i_abort;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            pulse_q <= (state_d == ST_ACTIVE);
            done_q  <= done_d;
        end
    end

    sat_counter #(
        .W (DROP_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (i_start && (state_q != ST_IDLE)),
        .cnt_o (o_drop_cnt)
    );

    assign o_pulse = pulse_q;
    assign o_done  = done_q;
    assign o_ready = (state_q == ST_IDLE);

endmodule
